// File: rtl/button_conditioner.sv
// Input stage for the five Basys3 push-buttons: two-flop synchronizer, per-button
// debounce counter, registered rise pulses, and press-toggled sel/en control state.
module button_conditioner #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btnl,
  input  logic       btnu,
  input  logic       btnd,
  input  logic       btnr,
  input  logic       btnc,
  output logic [4:0] btn_db,
  output logic [4:0] btn_rise,
  output logic [3:0] sel,
  output logic       en
);

  localparam int               NUM_BTN  = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync0;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] db_next;
  logic [NUM_BTN-1:0] rise_next;
  logic [CNT_W-1:0]   cnt      [NUM_BTN];
  logic [CNT_W-1:0]   cnt_next [NUM_BTN];

  assign raw = {btnc, btnr, btnd, btnu, btnl};

  // A mismatch must persist through the whole count; any agreement clears it.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      cnt_next[i] = '0;
      db_next[i]  = btn_db[i];
      if (sync1[i] != btn_db[i]) begin
        if (cnt[i] == LAST_CNT) begin
          db_next[i] = sync1[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rise and toggle are derived from db_next so they land on the same edge as db.
  assign rise_next = db_next & ~btn_db;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync0    <= '0;
      sync1    <= '0;
      btn_db   <= '0;
      btn_rise <= '0;
      sel      <= '0;
      en       <= 1'b0;
      // NOTE: the counter array is tiny and must restart on reset to abort any
      // count in progress, so every entry is cleared rather than left unreset.
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep sync0 -> sync1 a true two-stage
      // pipeline; blocking ones would collapse it into a single flop.
      sync0    <= raw;
      sync1    <= sync0;
      cnt      <= cnt_next;
      btn_db   <= db_next;
      btn_rise <= rise_next;
      sel      <= sel ^ rise_next[3:0];
      en       <= en ^ rise_next[4];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with STABLE_CYCLES=4, CNT_W=3: a raw level
// first sampled at edge 1 shows up on btn_db/btn_rise/sel/en after edge 6.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btnl = 1'b0;
  logic       btnu = 1'b0;
  logic       btnd = 1'b0;
  logic       btnr = 1'b0;
  logic       btnc = 1'b0;
  logic [4:0] btn_db;
  logic [4:0] btn_rise;
  logic [3:0] sel;
  logic       en;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btnl    (btnl),
    .btnu    (btnu),
    .btnd    (btnd),
    .btnr    (btnr),
    .btnc    (btnc),
    .btn_db  (btn_db),
    .btn_rise(btn_rise),
    .sel     (sel),
    .en      (en)
  );

  always #5 clk = ~clk;

  // One edge, then settle 1 ns so outputs are sampled well away from the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Button vector uses the btn_db order {c, r, d, u, l}.
  task automatic set_btn(input logic [4:0] v);
    btnl = v[0];
    btnu = v[1];
    btnd = v[2];
    btnr = v[3];
    btnc = v[4];
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] e_db, input logic [4:0] e_rise,
                           input logic [3:0] e_sel, input logic e_en);
    check({tag, ".db"},   btn_db,          e_db);
    check({tag, ".rise"}, btn_rise,        e_rise);
    check({tag, ".sel"},  {1'b0, sel},     {1'b0, e_sel});
    check({tag, ".en"},   {4'b0000, en},   {4'b0000, e_en});
  endtask

  task automatic do_reset();
    set_btn(5'b00000);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [8:0] bounce;
    bounce = 9'b1_1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1,1

    // Reset with btnl held for 3 edges.
    set_btn(5'b00001);
    reset_n = 1'b0;
    tick(3);
    check_all("reset_held", 5'b00000, 5'b00000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    tick(5);
    check("post_reset_edge5.db", btn_db, 5'b00000);
    tick();
    check_all("post_reset_edge6", 5'b00001, 5'b00001, 4'b0001, 1'b0);
    tick();
    check_all("post_reset_edge7", 5'b00001, 5'b00000, 4'b0001, 1'b0);

    // Clean press and release of btnu from a fresh reset.
    do_reset();
    set_btn(5'b00010);
    tick(5);
    check_all("btnu_edge5", 5'b00000, 5'b00000, 4'b0000, 1'b0);
    tick();
    check_all("btnu_edge6", 5'b00010, 5'b00010, 4'b0010, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_all("btnu_hold", 5'b00010, 5'b00000, 4'b0010, 1'b0);
    end
    set_btn(5'b00000);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("btnu_release_wait", 5'b00010, 5'b00000, 4'b0010, 1'b0);
    end
    tick();
    check_all("btnu_release_edge6", 5'b00000, 5'b00000, 4'b0010, 1'b0);

    // Bounce rejection on btnd: db rises at edge 10, 6 edges after the last 0->1 sample.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      set_btn({2'b00, bounce[k], 2'b00});
      tick();
      check("bounce_wait.db", btn_db, 5'b00000);
    end
    tick();
    check_all("bounce_edge10", 5'b00100, 5'b00100, 4'b0100, 1'b0);
    tick();
    check_all("bounce_edge11", 5'b00100, 5'b00000, 4'b0100, 1'b0);

    // Simultaneous btnd+btnr press starting from sel=0001.
    do_reset();
    set_btn(5'b00001);
    tick(6);
    check("sim_setup.sel", {1'b0, sel}, 5'b00001);
    set_btn(5'b00000);
    tick(6);
    check("sim_setup_release.db", btn_db, 5'b00000);
    set_btn(5'b01100);
    tick(5);
    check("sim_edge5.rise", btn_rise, 5'b00000);
    tick();
    check_all("sim_edge6", 5'b01100, 5'b01100, 4'b1101, 1'b0);
    tick();
    check_all("sim_edge7", 5'b01100, 5'b00000, 4'b1101, 1'b0);
    set_btn(5'b00000);
    tick(6);
    check_all("sim_release", 5'b00000, 5'b00000, 4'b1101, 1'b0);

    // Toggle sel[0] back, then two btnc presses toggle en up and down.
    set_btn(5'b00001);
    tick(6);
    check_all("btnl_toggle", 5'b00001, 5'b00001, 4'b1100, 1'b0);
    set_btn(5'b00000);
    tick(6);
    set_btn(5'b10000);
    tick(6);
    check_all("btnc_first", 5'b10000, 5'b10000, 4'b1100, 1'b1);
    set_btn(5'b00000);
    tick(6);
    check_all("btnc_first_release", 5'b00000, 5'b00000, 4'b1100, 1'b1);
    set_btn(5'b10000);
    tick(6);
    check_all("btnc_second", 5'b10000, 5'b10000, 4'b1100, 1'b0);
    set_btn(5'b00000);
    tick(6);

    // Reset in the middle of a btnc count; full re-count needed afterwards.
    set_btn(5'b10000);
    tick(4);
    check("midcount_pre.en", {4'b0000, en}, 5'b00000);
    reset_n = 1'b0;
    tick();
    check_all("midcount_reset", 5'b00000, 5'b00000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("midcount_recount", 5'b00000, 5'b00000, 4'b0000, 1'b0);
    end
    tick();
    check_all("midcount_edge6", 5'b10000, 5'b10000, 4'b0000, 1'b1);
    tick();
    check_all("midcount_edge7", 5'b10000, 5'b00000, 4'b0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
